// File: rtl/lw_sha_pkg.sv
// Shared types and constants for the lightweight SHA message-schedule path:
// FSM state encoding, round counts, sigma rotate/shift amounts and a width-generic rotate.
package lw_sha_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    ZERO
  } state_t;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  localparam int unsigned S256_S0_R0 = 7;
  localparam int unsigned S256_S0_R1 = 18;
  localparam int unsigned S256_S0_SH = 3;
  localparam int unsigned S256_S1_R0 = 17;
  localparam int unsigned S256_S1_R1 = 19;
  localparam int unsigned S256_S1_SH = 10;

  localparam int unsigned S512_S0_R0 = 1;
  localparam int unsigned S512_S0_R1 = 8;
  localparam int unsigned S512_S0_SH = 7;
  localparam int unsigned S512_S1_R0 = 19;
  localparam int unsigned S512_S1_R1 = 61;
  localparam int unsigned S512_S1_SH = 6;

  // Rotate the low 'width' bits of x right by amt (0 < amt < width <= 64).
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned amt,
                                      input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (((x & mask) >> amt) | (x << (width - amt))) & mask;
  endfunction

endpackage

// File: rtl/lw_sha_sched_sigma.sv
// Combinational message-schedule expansion:
// w_new = W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]), modulo 2^WORD_W.
module lw_sha_sched_sigma
  import lw_sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] w_m16,
  input  logic [WORD_W-1:0] w_m15,
  input  logic [WORD_W-1:0] w_m7,
  input  logic [WORD_W-1:0] w_m2,
  output logic [WORD_W-1:0] w_new
);

  localparam bit IS_512 = (WORD_W == 64);
  localparam int unsigned S0_R0 = IS_512 ? S512_S0_R0 : S256_S0_R0;
  localparam int unsigned S0_R1 = IS_512 ? S512_S0_R1 : S256_S0_R1;
  localparam int unsigned S0_SH = IS_512 ? S512_S0_SH : S256_S0_SH;
  localparam int unsigned S1_R0 = IS_512 ? S512_S1_R0 : S256_S1_R0;
  localparam int unsigned S1_R1 = IS_512 ? S512_S1_R1 : S256_S1_R1;
  localparam int unsigned S1_SH = IS_512 ? S512_S1_SH : S256_S1_SH;

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  always_comb begin
    s0 = WORD_W'(ror(64'(w_m15), S0_R0, WORD_W)) ^ WORD_W'(ror(64'(w_m15), S0_R1, WORD_W))
       ^ (w_m15 >> S0_SH);
    s1 = WORD_W'(ror(64'(w_m2), S1_R0, WORD_W)) ^ WORD_W'(ror(64'(w_m2), S1_R1, WORD_W))
       ^ (w_m2 >> S1_SH);
  end

  assign w_new = w_m16 + s0 + w_m7 + s1;

endmodule

// File: rtl/lw_sha_schedule_ctrl.sv
// Message-schedule sequencer: loads one 16-word block, then streams W[0..ROUNDS-1].
// Optional buffer zeroization after each block is enabled by LW_SHA_SCHED_ZEROIZE_EN.
module lw_sha_schedule_ctrl
  import lw_sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [WORD_W-1:0] msg_word_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [WORD_W-1:0] w_o,
  output logic [6:0]        round_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ROUNDS = (WORD_W == 64) ? ROUNDS_512 : ROUNDS_256;
  localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("lw_sha_schedule_ctrl: WORD_W must be 32 or 64");
    end
  endgenerate

`ifdef LW_SHA_SCHED_ZEROIZE_EN
  localparam state_t EXIT_STATE = ZERO;
`else
  localparam state_t EXIT_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [6:0]        t_q;
  logic [WORD_W-1:0] sched_q [16];
  logic              done_q;

  logic              msg_hs, w_hs, t_last, expanding;
  logic [3:0]        slot, tap15, tap7, tap2;
  logic [WORD_W-1:0] w_new, w_cur;

  // Circular taps: (t-15)%16, (t-7)%16 and (t-2)%16 via 4-bit wrap-around.
  assign slot  = t_q[3:0];
  assign tap15 = slot + 4'd1;
  assign tap7  = slot + 4'd9;
  assign tap2  = slot + 4'd14;

  lw_sha_sched_sigma #(.WORD_W(WORD_W)) u_sigma (
    .w_m16 (sched_q[slot]),
    .w_m15 (sched_q[tap15]),
    .w_m7  (sched_q[tap7]),
    .w_m2  (sched_q[tap2]),
    .w_new (w_new)
  );

  assign expanding = (t_q[6:4] != 3'd0);
  assign w_cur     = expanding ? w_new : sched_q[slot];
  assign t_last    = (t_q == T_LAST);

  assign msg_ready_o = (state_q == LOAD);
  assign w_valid_o   = (state_q == EXPAND);
  assign w_o         = w_valid_o ? w_cur : '0;
  assign round_o     = t_q;
  assign last_o      = w_valid_o && t_last;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

  assign msg_hs = msg_ready_o && msg_valid_i && !abort_i;
  assign w_hs   = w_valid_o && w_ready_i && !abort_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !abort_i) state_d = LOAD;
      LOAD:    if (abort_i) state_d = EXIT_STATE;
               else if (msg_hs && cnt_q == 4'd15) state_d = EXPAND;
      EXPAND:  if (abort_i) state_d = EXIT_STATE;
               else if (w_hs && t_last) state_d = EXIT_STATE;
      ZERO:    if (!abort_i && cnt_q == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the buffer is cleared by the async reset so no stale block survives a reset;
  // this is a small register file, not an inferred RAM, so the reset is affordable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      t_q    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 16; i++) sched_q[i] <= '0;
    end else begin
      done_q <= w_hs && t_last;
      if (abort_i) begin
        cnt_q <= '0;
        t_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            t_q   <= '0;
          end
          LOAD: if (msg_hs) begin
            sched_q[cnt_q] <= msg_word_i;
            cnt_q          <= cnt_q + 4'd1;
          end
          EXPAND: if (w_hs) begin
            if (expanding) sched_q[slot] <= w_new;
            t_q <= t_last ? 7'd0 : t_q + 7'd1;
          end
          ZERO: begin
            sched_q[cnt_q] <= '0;
            cnt_q          <= cnt_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lw_sha_schedule_ctrl.sv
// Self-checking bench: a SHA-256 and a SHA-512 instance checked every cycle against a
// reference schedule built from the standard W[t] recurrence over a full W array.
module tb_lw_sha_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start, abort, msg_valid, w_ready;
  logic [1:0]  msg_ready, w_valid, last, busy, done;
  logic [63:0] msg_word;
  logic [31:0] w32;
  logic [63:0] w64;
  logic [6:0]  round_obs [2];
  logic [63:0] w_obs [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] cur_blk [2][16];
  logic [63:0] exp_w   [2][80];
  int          idx      [2];
  bit          pend     [2];
  int          hs_total [2];

  always #5 clk = ~clk;

  lw_sha_schedule_ctrl #(.WORD_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .abort_i(abort[0]),
    .msg_valid_i(msg_valid[0]), .msg_ready_o(msg_ready[0]), .msg_word_i(msg_word[31:0]),
    .w_valid_o(w_valid[0]), .w_ready_i(w_ready[0]), .w_o(w32), .round_o(round_obs[0]),
    .last_o(last[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  lw_sha_schedule_ctrl #(.WORD_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .abort_i(abort[1]),
    .msg_valid_i(msg_valid[1]), .msg_ready_o(msg_ready[1]), .msg_word_i(msg_word),
    .w_valid_o(w_valid[1]), .w_ready_i(w_ready[1]), .w_o(w64), .round_o(round_obs[1]),
    .last_o(last[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  assign w_obs[0] = {32'd0, w32};
  assign w_obs[1] = w64;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int rounds_of(input int d);
    return (d != 0) ? 80 : 64;
  endfunction

  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] m_s0(input logic [63:0] x, input int w);
    if (w == 32) return m_ror(x, 7, 32) ^ m_ror(x, 18, 32) ^ (x >> 3);
    return m_ror(x, 1, 64) ^ m_ror(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] m_s1(input logic [63:0] x, input int w);
    if (w == 32) return m_ror(x, 17, 32) ^ m_ror(x, 19, 32) ^ (x >> 10);
    return m_ror(x, 19, 64) ^ m_ror(x, 61, 64) ^ (x >> 6);
  endfunction

  // Reference schedule over the full W array (no circular buffer).
  task automatic build_model(input int d);
    int w;
    logic [63:0] m;
    w = (d != 0) ? 64 : 32;
    m = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) exp_w[d][t] = cur_blk[d][t] & m;
    for (int t = 16; t < 80; t++)
      exp_w[d][t] = (exp_w[d][t-16] + m_s0(exp_w[d][t-15], w) + exp_w[d][t-7]
                     + m_s1(exp_w[d][t-2], w)) & m;
  endtask

  task automatic set_abc(input int d);
    for (int i = 0; i < 16; i++) cur_blk[d][i] = 64'd0;
    cur_blk[d][0]  = (d != 0) ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
    cur_blk[d][15] = 64'h18;
  endtask

  task automatic set_zero(input int d);
    for (int i = 0; i < 16; i++) cur_blk[d][i] = 64'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag);
    check($sformatf("%s_d%0d_msg_ready", tag, d), 64'(msg_ready[d]), 64'd0);
    check($sformatf("%s_d%0d_w_valid", tag, d), 64'(w_valid[d]), 64'd0);
    check($sformatf("%s_d%0d_last", tag, d), 64'(last[d]), 64'd0);
    check($sformatf("%s_d%0d_busy", tag, d), 64'(busy[d]), 64'd0);
    check($sformatf("%s_d%0d_done", tag, d), 64'(done[d]), 64'd0);
    check($sformatf("%s_d%0d_w", tag, d), w_obs[d], 64'd0);
    check($sformatf("%s_d%0d_round", tag, d), 64'(round_obs[d]), 64'd0);
  endtask

  // Per-cycle scoreboard: expected W index advances on each accepted output word.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        idx[d]  = 0;
        pend[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_done_pulse", d), 64'(done[d]), 64'(pend[d]));
        pend[d] = 1'b0;
        check($sformatf("d%0d_last_t%0d", d, idx[d]), 64'(last[d]),
              64'(w_valid[d] && idx[d] == rounds_of(d) - 1));
        if (w_valid[d]) begin
          check($sformatf("d%0d_round_t%0d", d, idx[d]), 64'(round_obs[d]), 64'(idx[d]));
          check($sformatf("d%0d_w_t%0d", d, idx[d]), w_obs[d], exp_w[d][idx[d]]);
          if (w_ready[d] && !abort[d]) begin
            hs_total[d]++;
            if (idx[d] == rounds_of(d) - 1) begin
              pend[d] = 1'b1;
              idx[d]  = 0;
            end else begin
              idx[d]++;
            end
          end
        end
        if (abort[d]) idx[d] = 0;
      end
    end
  end

  task automatic load_block(input int d, input bit toggle);
    build_model(d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (toggle) begin
        msg_valid[d] = 1'b0;
        msg_word     = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      msg_valid[d] = 1'b1;
      msg_word     = cur_blk[d][i];
      tick();
    end
    msg_valid[d] = 1'b0;
    check($sformatf("d%0d_first_w_latency", d), 64'(w_valid[d]), 64'd1);
    check($sformatf("d%0d_ready_after_16", d), 64'(msg_ready[d]), 64'd0);
    check($sformatf("d%0d_first_w_is_word0", d), w_obs[d], cur_blk[d][0]);
  endtask

  // Drive w_ready high until done_o (or until round stop_at appears), optional 5-cycle stall.
  task automatic run_block(input int d, input int stall_at, input int stop_at);
    int base;
    bit fin, seen_done, stalled;
    base = hs_total[d];
    fin = 1'b0;
    seen_done = 1'b0;
    stalled = 1'b0;
    w_ready[d] = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (stop_at >= 0 && w_valid[d] && round_obs[d] == 7'(stop_at)) begin
        fin = 1'b1;
      end else begin
        if (stall_at >= 0 && !stalled && w_valid[d] && round_obs[d] == 7'(stall_at)) begin
          w_ready[d] = 1'b0;
          repeat (5) begin
            tick();
            check("stall_w_hold", w_obs[d], exp_w[d][stall_at]);
            check("stall_round_hold", 64'(round_obs[d]), 64'(stall_at));
          end
          w_ready[d] = 1'b1;
          stalled = 1'b1;
        end
        tick();
        if (done[d]) begin
          fin = 1'b1;
          seen_done = 1'b1;
          check($sformatf("d%0d_busy_at_done", d), 64'(busy[d]), 64'd0);
          check($sformatf("d%0d_handshakes", d), 64'(hs_total[d] - base), 64'(rounds_of(d)));
        end
      end
    end
    if (stop_at < 0 && !seen_done) check($sformatf("d%0d_done_timeout", d), 64'd0, 64'd1);
    if (stop_at < 0) w_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    msg_valid = '0;
    w_ready = '0;
    msg_word = '0;
    for (int d = 0; d < 2; d++) begin
      hs_total[d] = 0;
      set_zero(d);
      build_model(d);
    end
    #12;
    check_idle(0, "reset");
    check_idle(1, "reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // SHA-256 "abc" block, no stalls.
    set_abc(0);
    build_model(0);
    check("model_abc_w16", exp_w[0][16], 64'h6162_6380);
    check("model_abc_w17", exp_w[0][17], 64'h000F_0000);
    check("model_abc_w18", exp_w[0][18], 64'h7DA8_6405);
    check("model_abc_w19", exp_w[0][19], 64'h6000_03C6);
    load_block(0, 1'b0);
    run_block(0, -1, -1);
    tick();

    // Input stalls, backpressure at t=20, start_i held high while busy.
    load_block(0, 1'b1);
    start[0] = 1'b1;
    run_block(0, 20, -1);
    start[0] = 1'b0;
    tick();

    // Abort at t=30 coincident with a handshake, then restart.
    load_block(0, 1'b0);
    run_block(0, -1, 30);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    w_ready[0] = 1'b0;
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_w_valid", 64'(w_valid[0]), 64'd0);
    check("abort_msg_ready", 64'(msg_ready[0]), 64'd0);
    repeat (3) tick();
    check("abort_no_done", 64'(done[0]), 64'd0);
    load_block(0, 1'b0);
    run_block(0, -1, -1);
    tick();

    // Reset in the middle of LOAD with 7 words accepted.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      msg_valid[0] = 1'b1;
      msg_word = 64'(i + 1);
      tick();
    end
    msg_valid[0] = 1'b0;
    check("midload_msg_ready", 64'(msg_ready[0]), 64'd1);
    rst_n = 1'b0;
    #2;
    check_idle(0, "midload_rst");
    #4 rst_n = 1'b1;
    tick();

    // All-zero blocks at both widths.
    set_zero(0);
    load_block(0, 1'b0);
    run_block(0, -1, -1);
    tick();
    set_zero(1);
    load_block(1, 1'b0);
    run_block(1, -1, -1);
    tick();

    // SHA-512 "abc" block.
    set_abc(1);
    build_model(1);
    check("model512_w16", exp_w[1][16], 64'h6162_6380_0000_0000);
    check("model512_w17", exp_w[1][17], 64'h0003_0000_0000_00C0);
    load_block(1, 1'b1);
    run_block(1, 40, -1);
    repeat (2) tick();
    check_idle(0, "end");
    check_idle(1, "end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
